tof_hit_seq: RTL and testbench
==============================

# tof_hit_seq

Capture-side sequencer that feeds `tof_cal`. It records one start hit and up to five stop hits per measurement. For each hit it stores the 16-bit phase snapshot and the coarse elapsed-cycle count. When the window closes it drives the calculator's `tri_en`, `num_cnt`, `cnt`, `cal_en`, `decode_in` and `counter_in` inputs, replaying the stored hits one by one at the burst cadence the calculator's 5-stage pipeline expects.

## Interface
Parameters:
- `WINDOW`, 16000: capture window in clk cycles after the start hit; max 16382.
- `GAP`, 8: idle cycles between bursts, with outputs held stable; min 8.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `arm`  in  1  1-cycle pulse that starts or restarts a measurement
- `hit_in`  in  1  synchronous hit strobe
- `phase_in`  in  16  twisted-ring phase snapshot; valid when `hit_in`=1
- `cal_stop`  in  1  calculator burst-progress flag
- `decode_out`  out  16  phase word to calculator `decode_in`
- `counter_out`  out  26  coarse word to calculator `counter_in`
- `cnt`  out  3  hit index of the current burst: 1 = start, 2..6 = stops
- `num_cnt`  out  3  number of stops captured (0..5)
- `cal_en`  out  1  calculator pipeline enable
- `tri_en`  out  1  1-cycle frame-close pulse
- `busy`  out  1  high in every state except IDLE
- `hit_ovf`  out  1  sticky flag: a hit arrived after five stops had been stored
- `seq_err`  out  1  sticky flag: `cal_stop` was not seen on burst cycle 4

## Operation
- FSM states: IDLE, ARMED, RUN, CLOSE, BURST, GAP.
- **IDLE**
  - `arm` → ARMED.
  - Clears the buffer, `num_cnt`, `hit_ovf` and `seq_err`.
- **ARMED**
  - First `hit_in` stores entry 0 with phase and E=0, then → RUN.
  - `arm` here re-arms (stays in ARMED).
  - No timeout.
- **RUN**
  - Elapsed counter E increments every cycle.
  - Each `hit_in` stores entry n+1 with {`phase_in`, E} and increments `num_cnt`.
  - → CLOSE when E reaches `WINDOW`, or on the cycle after the 5th stop is stored.
  - A hit on the same cycle as the window close is dropped.
  - A hit while 5 stops are already stored sets `hit_ovf`.
  - `arm` is ignored.
- **CLOSE**
  - Asserts `tri_en` for one cycle; `num_cnt` is already stable.
  - → BURST with index k=0.
- **BURST**
  - Presents entry k: `decode_out`=phase, `counter_out`=coarse(E), `cnt`=k+1.
  - Holds `cal_en`=1 for exactly 5 cycles.
  - Samples `cal_stop` on the 5th cycle; if it is 0, sets `seq_err`.
  - → GAP.
- **GAP**
  - `cal_en`=0, all data outputs held.
  - After `GAP` cycles: if k < `num_cnt`, increment k and → BURST; else → IDLE.
  - Entry count is always `num_cnt`+1.
- **Coarse packing:** `counter_out` = {ceil(E/2)[12:0], floor(E/2)[12:0]}. The calculator adds the two halves, so their sum equals E exactly. E saturates at 16382.
- `arm` in BURST or GAP is ignored; a frame always completes.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - E and buffer cleared
- `arm` sampled at edge t → `busy`=1 from t+1.
- Start hit sampled at edge s → stop hit at edge s+d records E=d.
- 5th stop sampled at edge p → `tri_en` high during cycle p+1 to p+2; first `cal_en` at p+2.
- Burst period is 5+`GAP` cycles. `decode_out`, `counter_out` and `cnt` change only on the first cycle of a burst.
- `busy` drops on the cycle after the final GAP ends.
- Reset mid-frame: immediate return to the reset state. `cal_en` drops asynchronously; no partial burst resumes.

## Structure
- Shared package `tof_pkg`:
  - `MAX_STOPS`=5
  - `CAL_BURST`=5
  - `CNT_START`=1
  - FSM state enum
  - entry struct {phase[15:0], elapsed[13:0]}
- Sub-module `tof_hit_buf`:
  - 6×30-bit register file
  - write port indexed by capture count, read port indexed by k
  - synchronous clear

## Test plan
- **Start plus stops:** `arm`, start with `phase_in`=16'h00FF, stops at d=100 and d=5000, window expires.
  - `tri_en` once, `num_cnt`=2.
  - Three bursts with `cnt`=1,2,3.
  - `counter_out` = 0, {50,50}, {2500,2500}.
- **Five stops plus one extra:** five stops at d=1..5, sixth hit at d=6.
  - CLOSE one cycle after the 5th stop; the sixth hit is dropped.
  - `hit_ovf`=1, `num_cnt`=5, 6 bursts.
- **Odd E:** stop at d=7.
  - `counter_out` = {13'd4, 13'd3}.
- **Window saturation:** `WINDOW`=16382, no stops.
  - `num_cnt`=0, single burst with `cnt`=1; E never exceeds 16382.
- **Burst checks:** hold `cal_stop`=0.
  - `seq_err`=1.
  - `cal_en` high exactly 5 cycles per burst, gaps exactly `GAP` cycles.
  - `arm` during GAP is ignored.
- **Reset mid-BURST:** assert `rst_n`=0 during a burst.
  - All outputs 0 immediately.
  - After release: IDLE, and `arm` starts a clean frame.

Source files
------------

// File: rtl/tof_pkg.sv
// tof_pkg: shared constants, FSM states and hit-entry layout for the ToF capture sequencer
package tof_pkg;
    localparam int MAX_STOPS = 5;
    localparam int CAL_BURST = 5;
    localparam logic [2:0] CNT_START = 3'd1;
    localparam logic [13:0] E_MAX = 14'd16382;
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_CLOSE, S_BURST, S_GAP} state_t;
    typedef struct packed {
        logic [15:0] phase;
        logic [13:0] elapsed;
    } entry_t;
    // Split E into ceil/floor halves so the calculator's sum restores E exactly
    function automatic logic [25:0] coarse(input logic [13:0] e);
        logic [14:0] c;
        c = ({1'b0, e} + 15'd1) >> 1;
        return {c[12:0], e[13:1]};
    endfunction
endpackage

// File: rtl/tof_hit_buf.sv
// tof_hit_buf: start + stop hit register file with one write and one read port
module tof_hit_buf
    import tof_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [29:0] wdata,
    input  logic [2:0]  raddr,
    output logic [29:0] rdata
);
    logic [29:0] mem [0:MAX_STOPS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i <= MAX_STOPS; i++) mem[i] <= '0;
        else if (clr)
            for (int i = 0; i <= MAX_STOPS; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/tof_hit_seq.sv
// tof_hit_seq: captures start/stop hits and replays them to tof_cal in paced bursts
module tof_hit_seq
    import tof_pkg::*;
#(
    parameter int WINDOW = 16000,
    parameter int GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        hit_in,
    input  logic [15:0] phase_in,
    input  logic        cal_stop,
    output logic [15:0] decode_out,
    output logic [25:0] counter_out,
    output logic [2:0]  cnt,
    output logic [2:0]  num_cnt,
    output logic        cal_en,
    output logic        tri_en,
    output logic        busy,
    output logic        hit_ovf,
    output logic        seq_err
);
    state_t state, nxt;
    logic [13:0] e;
    logic [2:0] k, waddr, raddr;
    logic [15:0] t;
    logic [29:0] rdata;
    logic closing, we, load, burst_done, gap_done;
    // Closing wins over a same-cycle hit, so hits on the close edge are dropped
    assign closing = state == S_RUN && (e == 14'(WINDOW) || num_cnt == 3'(MAX_STOPS));
    assign we = hit_in && (state == S_ARMED || (state == S_RUN && !closing));
    assign waddr = state == S_ARMED ? 3'd0 : num_cnt + 3'd1;
    assign raddr = state == S_CLOSE ? 3'd0 : k + 3'd1;
    assign burst_done = t == 16'(CAL_BURST - 1);
    assign gap_done = t == 16'(GAP - 1);
    assign load = nxt == S_BURST && state != S_BURST;
    assign cal_en = state == S_BURST;
    assign tri_en = state == S_CLOSE;
    assign busy = state != S_IDLE;
    tof_hit_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_IDLE),
        .we    (we),
        .waddr (waddr),
        .wdata ({phase_in, state == S_ARMED ? 14'd0 : e}),
        .raddr (raddr),
        .rdata (rdata)
    );
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = arm ? S_ARMED : S_IDLE;
            S_ARMED: nxt = hit_in ? S_RUN : S_ARMED;
            S_RUN:   nxt = closing ? S_CLOSE : S_RUN;
            S_CLOSE: nxt = S_BURST;
            S_BURST: nxt = burst_done ? S_GAP : S_BURST;
            S_GAP:   nxt = !gap_done ? S_GAP : k < num_cnt ? S_BURST : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            e <= '0;
            k <= '0;
            t <= '0;
            num_cnt <= '0;
            hit_ovf <= 1'b0;
            seq_err <= 1'b0;
            decode_out <= '0;
            counter_out <= '0;
            cnt <= '0;
        end else begin
            state <= nxt;
            t <= nxt != state ? '0 : t + 16'd1;
            // E is 1 on the cycle after the start edge, so a stop d edges later records d
            e <= state == S_ARMED ? 14'd1 : state != S_RUN ? 14'd0 : e == E_MAX ? e : e + 14'd1;
            if (state == S_IDLE) begin
                num_cnt <= '0;
                hit_ovf <= 1'b0;
                seq_err <= 1'b0;
            end
            if (we && state == S_RUN) num_cnt <= num_cnt + 3'd1;
            if (state == S_RUN && hit_in && num_cnt == 3'(MAX_STOPS)) hit_ovf <= 1'b1;
            if (state == S_BURST && burst_done && !cal_stop) seq_err <= 1'b1;
            if (load) begin
                k <= raddr;
                decode_out <= rdata[29:14];
                counter_out <= coarse(rdata[13:0]);
                cnt <= raddr + CNT_START;
            end
        end
    end
endmodule

// File: tb/tb_tof_hit_seq.sv
// tb_tof_hit_seq: directed self-checking bench for tof_hit_seq
module tb_tof_hit_seq;
    localparam int GAP = 8;
    logic clk = 0, rst_n = 0, arm = 0, hit_in = 0, cal_stop = 1;
    logic [15:0] phase_in = '0, decode_out;
    logic [25:0] counter_out;
    logic [2:0] cnt, num_cnt;
    logic cal_en, tri_en, busy, hit_ovf, seq_err;
    int tests = 0, fails = 0;

    tof_hit_seq #(.WINDOW(16382), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .hit_in(hit_in), .phase_in(phase_in),
        .cal_stop(cal_stop), .decode_out(decode_out), .counter_out(counter_out),
        .cnt(cnt), .num_cnt(num_cnt), .cal_en(cal_en), .tri_en(tri_en), .busy(busy),
        .hit_ovf(hit_ovf), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hit(input logic [15:0] p);
        hit_in = 1;
        phase_in = p;
        tick(1);
        hit_in = 0;
    endtask

    task automatic start_frame(input logic [15:0] p);
        arm = 1;
        tick(1);
        arm = 0;
        tick(2);
        hit(p);
    endtask

    task automatic wait_tri(input int exp);
        int n = 0;
        while (!tri_en && n < 20000) begin
            tick(1);
            n++;
        end
        chk("tri_delay", n, exp);
        tick(1);
        chk("tri_width", {31'd0, tri_en}, 0);
        chk("cal_en_start", {31'd0, cal_en}, 1);
    endtask

    task automatic burst(input logic [2:0] ec, input logic [15:0] ed, input logic [25:0] eo,
                         input logic ee, input logic parm);
        int n = 0, m = 0;
        chk("cnt", {29'd0, ec} ^ {29'd0, cnt} ^ {29'd0, ec}, {29'd0, ec});
        chk("decode_out", {16'd0, decode_out}, {16'd0, ed});
        chk("counter_out", {6'd0, counter_out}, {6'd0, eo});
        while (cal_en && n < 20) begin
            tick(1);
            n++;
        end
        chk("cal_en_len", n, 5);
        chk("seq_err", {31'd0, seq_err}, {31'd0, ee});
        chk("cnt_hold", {29'd0, cnt}, {29'd0, ec});
        while (!cal_en && busy && m < 20) begin
            if (parm && m == 2) arm = 1;
            tick(1);
            arm = 0;
            m++;
        end
        chk("gap_len", m, GAP);
    endtask

    initial begin
        tick(2);
        chk("rst_decode", {16'd0, decode_out}, 0);
        chk("rst_counter", {6'd0, counter_out}, 0);
        chk("rst_cnt", {29'd0, cnt}, 0);
        chk("rst_num_cnt", {29'd0, num_cnt}, 0);
        chk("rst_cal_en", {31'd0, cal_en}, 0);
        chk("rst_tri_en", {31'd0, tri_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_hit_ovf", {31'd0, hit_ovf}, 0);
        chk("rst_seq_err", {31'd0, seq_err}, 0);
        rst_n = 1;
        tick(2);

        // start plus two stops, window expiry
        chk("idle_busy", {31'd0, busy}, 0);
        arm = 1;
        tick(1);
        arm = 0;
        chk("arm_busy", {31'd0, busy}, 1);
        tick(2);
        hit(16'h00FF);
        tick(99);
        hit(16'h1234);
        tick(4899);
        hit(16'hABCD);
        wait_tri(11382);
        chk("t1_num_cnt", {29'd0, num_cnt}, 2);
        burst(3'd1, 16'h00FF, 26'd0, 0, 0);
        burst(3'd2, 16'h1234, {13'd50, 13'd50}, 0, 0);
        burst(3'd3, 16'hABCD, {13'd2500, 13'd2500}, 0, 0);
        chk("t1_busy_end", {31'd0, busy}, 0);
        tick(3);

        // five stops plus an extra hit
        start_frame(16'hA000);
        for (int i = 1; i <= 5; i++) hit(16'hA000 + 16'(i));
        chk("t2_tri_early", {31'd0, tri_en}, 0);
        hit(16'hA006);
        chk("t2_hit_ovf", {31'd0, hit_ovf}, 1);
        chk("t2_num_cnt", {29'd0, num_cnt}, 5);
        wait_tri(0);
        burst(3'd1, 16'hA000, 26'd0, 0, 0);
        burst(3'd2, 16'hA001, {13'd1, 13'd0}, 0, 0);
        burst(3'd3, 16'hA002, {13'd1, 13'd1}, 0, 0);
        burst(3'd4, 16'hA003, {13'd2, 13'd1}, 0, 0);
        burst(3'd5, 16'hA004, {13'd2, 13'd2}, 0, 0);
        burst(3'd6, 16'hA005, {13'd3, 13'd2}, 0, 0);
        tick(3);

        // odd E, missing cal_stop, arm during GAP
        cal_stop = 0;
        start_frame(16'h7777);
        tick(6);
        for (int i = 7; i <= 11; i++) hit(16'(i));
        wait_tri(1);
        burst(3'd1, 16'h7777, 26'd0, 1, 1);
        burst(3'd2, 16'h0007, {13'd4, 13'd3}, 1, 0);
        burst(3'd3, 16'h0008, {13'd4, 13'd4}, 1, 0);
        burst(3'd4, 16'h0009, {13'd5, 13'd4}, 1, 0);
        burst(3'd5, 16'h000A, {13'd5, 13'd5}, 1, 0);
        burst(3'd6, 16'h000B, {13'd6, 13'd5}, 1, 0);
        tick(2);
        chk("t3_arm_ignored", {31'd0, busy}, 0);
        cal_stop = 1;

        // full window, no stops
        start_frame(16'h5555);
        wait_tri(16382);
        chk("t4_num_cnt", {29'd0, num_cnt}, 0);
        burst(3'd1, 16'h5555, 26'd0, 0, 0);
        chk("t4_busy_end", {31'd0, busy}, 0);
        tick(3);

        // reset in the middle of a burst
        start_frame(16'h1111);
        for (int i = 1; i <= 5; i++) hit(16'h2220 + 16'(i));
        wait_tri(1);
        tick(2);
        #3 rst_n = 0;
        #1;
        chk("mid_rst_cal_en", {31'd0, cal_en}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_cnt", {29'd0, cnt}, 0);
        chk("mid_rst_decode", {16'd0, decode_out}, 0);
        chk("mid_rst_counter", {6'd0, counter_out}, 0);
        chk("mid_rst_num_cnt", {29'd0, num_cnt}, 0);
        tick(2);
        rst_n = 1;
        tick(3);
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_cal_en", {31'd0, cal_en}, 0);
        start_frame(16'h3333);
        for (int i = 1; i <= 5; i++) hit(16'h4440 + 16'(i));
        wait_tri(1);
        chk("t5_num_cnt", {29'd0, num_cnt}, 5);
        chk("t5_hit_ovf", {31'd0, hit_ovf}, 0);
        burst(3'd1, 16'h3333, 26'd0, 0, 0);
        burst(3'd2, 16'h4441, {13'd1, 13'd0}, 0, 0);
        burst(3'd3, 16'h4442, {13'd1, 13'd1}, 0, 0);
        burst(3'd4, 16'h4443, {13'd2, 13'd1}, 0, 0);
        burst(3'd5, 16'h4444, {13'd2, 13'd2}, 0, 0);
        burst(3'd6, 16'h4445, {13'd3, 13'd2}, 0, 0);
        chk("t5_busy_end", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
